// File: rtl/pulse_gen_pkg.sv
// Shared types and default sizes for the pulse-train stimulus generator.
package pulse_gen_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_GAP_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    TRIG  = 2'd3
  } state_t;
endpackage

// File: rtl/pulse_train_gen.sv
// Emits N increment pulses spaced G+1 cycles apart, then one trigger pulse,
// to drive the increment/trigger interface of the event counter.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             ready,
  output logic             increment,
  output logic             trigger,
  output logic             busy
);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   remaining, remaining_nx;
  logic [GAP_W-1:0]   gap_reg, gap_reg_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      gap_reg   <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      gap_reg   <= gap_reg_nx;
      gap_cnt   <= gap_cnt_nx;
    end
  end

  // PULSE is only ever entered with remaining >= 1, so the decrement cannot wrap.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    gap_reg_nx   = gap_reg;
    gap_cnt_nx   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          remaining_nx = count;
          gap_reg_nx   = gap;
          state_nx     = (count == '0) ? TRIG : PULSE;
        end
      end
      PULSE: begin
        remaining_nx = remaining - 1'b1;
        if (abort)                 state_nx = IDLE;
        else if (gap_reg != '0) begin
          state_nx   = GAP;
          gap_cnt_nx = gap_reg;
        end
        else if (remaining == WIDTH'(1)) state_nx = TRIG;
        else                       state_nx = PULSE;
      end
      GAP: begin
        gap_cnt_nx = gap_cnt - 1'b1;
        if (abort)                         state_nx = IDLE;
        else if (gap_cnt <= GAP_W'(1))     state_nx = (remaining == '0) ? TRIG : PULSE;
      end
      TRIG: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pulses decode straight from the state register, so they are glitch-free and exclusive.
  assign increment = (state == PULSE);
  assign trigger   = (state == TRIG);
  assign busy      = (state != IDLE);
  assign ready     = (state == IDLE) && !rst;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: table of bursts plus hand-written corner sequences.
module tb_pulse_train_gen;
  localparam int WIDTH = 64;
  localparam int GAP_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             ready, increment, trigger, busy;

  int checks = 0;
  int errors = 0;

  pulse_train_gen #(.WIDTH(WIDTH), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .gap(gap), .abort(abort),
    .ready(ready), .increment(increment), .trigger(trigger), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] n;
    logic [GAP_W-1:0] g;
    int               abort_k;   // abort on the k-th increment cycle, 0 = none
    int               cycles;    // cycles observed after acceptance
    int               exp_total; // counter value expected after the burst
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the burst.
  task automatic run_burst(input vec_t v);
    logic [95:0] n96, stride, endc, k;
    int          total;
    int          abort_c;
    logic        e_inc, e_trig, e_rdy;
    n96     = 96'(v.n);
    stride  = 96'(v.g) + 96'd1;
    abort_c = (v.abort_k == 0) ? 0 : 1 + (v.abort_k - 1) * int'(stride);
    endc    = (v.abort_k == 0) ? n96 * stride + 96'd1 : 96'(abort_c);
    total   = 0;
    chk("ready_before_start", 64'(ready), 64'd1);
    start = 1'b1; count = v.n; gap = v.g;
    for (int c = 1; c <= v.cycles; c++) begin
      @(negedge clk);
      start = 1'b0;
      count = {$urandom, $urandom};
      gap   = GAP_W'($urandom);
      k      = 96'((c - 1) / int'(stride)) + 96'd1;
      e_inc  = ((c - 1) % int'(stride) == 0) && (k <= n96) &&
               (v.abort_k == 0 || k <= 96'(v.abort_k));
      e_trig = (v.abort_k == 0) && (96'(c) == endc);
      e_rdy  = 96'(c) > endc;
      if (increment) total++;
      if (increment !== e_inc || trigger !== e_trig || ready !== e_rdy || busy !== !e_rdy) begin
        chk($sformatf("burst n=%0h g=%0d cyc=%0d {inc,trig,rdy,busy}", v.n, v.g, c),
            64'({increment, trigger, ready, busy}), 64'({e_inc, e_trig, e_rdy, !e_rdy}));
      end else begin
        checks++;
      end
      abort = (c == abort_c);
    end
    abort = 1'b0;
    chk($sformatf("counter total n=%0h g=%0d", v.n, v.g), 64'(total), 64'(v.exp_total));
  endtask

  initial begin
    vecs[0] = '{64'd3,  16'd0,     0, 6,     3};
    vecs[1] = '{64'd2,  16'd2,     0, 10,    2};
    vecs[2] = '{64'd0,  16'd5,     0, 4,     0};
    vecs[3] = '{64'd10, 16'd1,     4, 12,    4};
    vecs[4] = '{64'd4,  16'd3,     0, 20,    4};
    vecs[5] = '{'1,     16'd0,   100, 103, 100};
    vecs[6] = '{64'd1,  16'hffff,  0, 65539, 1};

    rst = 1'b1; start = 1'b0; count = '0; gap = '0; abort = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset {inc,trig,busy}", 64'({increment, trigger, busy}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset ready", 64'(ready), 64'd1);

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // start during TRIG is ignored and not queued
    start = 1'b1; count = 64'd0; gap = 16'd5;
    @(negedge clk);
    chk("n0 trig", 64'({increment, trigger}), 64'b01);
    count = 64'd7;
    @(negedge clk);
    chk("n0 after trig idle", 64'({increment, trigger, ready, busy}), 64'b0010);
    start = 1'b0;
    @(negedge clk);
    chk("start in TRIG ignored", 64'({increment, busy}), 64'd0);

    // start with abort in IDLE is accepted
    start = 1'b1; abort = 1'b1; count = 64'd1; gap = 16'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start+abort inc", 64'({increment, busy}), 64'b11);
    @(negedge clk);
    chk("start+abort trig", 64'(trigger), 64'd1);
    @(negedge clk);

    // reset mid-burst after the 2nd increment
    start = 1'b1; count = 64'd5; gap = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("rst seq inc1", 64'(increment), 64'd1);
    @(negedge clk);
    chk("rst seq inc2", 64'(increment), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst seq outputs", 64'({increment, trigger, busy, ready}), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rst seq idle %0d", c), 64'({increment, trigger, busy, ready}), 64'b0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Stimulus generator that drives the increment/trigger interface of the team's 64-bit event counter. The block accepts a requested count N and a gap length G, emits exactly N single-cycle `increment` pulses spaced G+1 cycles apart, then one single-cycle `trigger` pulse. A counter fed by this block reports exactly N. The block sits in test and bring-up fixtures ahead of the counter and is the transmitting end of that interface.

## Interface
- `WIDTH`, 64: width of the requested count; matches the counter output width.
- `GAP_W`, 16: width of the gap field.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request valid; accepted only when `ready`=1.
- `count`  in  WIDTH  pulses to emit (N); sampled on acceptance.
- `gap`  in  GAP_W  idle cycles between pulses (G); sampled on acceptance.
- `abort`  in  1  cancels an in-flight burst.
- `ready`  out  1  block idle and able to accept `start`.
- `increment`  out  WIDTH-independent, 1  one-cycle event pulse.
- `trigger`  out  1  one-cycle end-of-burst pulse.
- `busy`  out  1  burst in flight (PULSE, GAP or TRIG state).

## Operation
- States: IDLE, PULSE, GAP, TRIG.
- **IDLE**
  - `ready`=1.
  - On `start`, latch `count` into `remaining` and `gap` into `gap_reg`.
  - If N=0, go to TRIG; otherwise go to PULSE.
- **PULSE**
  - `increment`=1 for this cycle; decrement `remaining`.
  - Next state:
    - G>0: go to GAP, with the gap counter loaded to G.
    - G=0 and `remaining` was 1: go to TRIG.
    - Otherwise: stay in PULSE.
- **GAP**
  - Outputs idle; the gap counter counts down.
  - When it reaches 0: go to TRIG if `remaining`=0, else go to PULSE.
- **TRIG**
  - `trigger`=1 for one cycle, then go to IDLE.
- **Pulse spacing**
  - Trigger uses the same G+1 spacing after the last increment, so `increment` and `trigger` are never high in the same cycle.
- **Outputs**
  - `increment` and `trigger` are registered, state-derived pulses; never both high.
  - `ready` = (state==IDLE) && !`rst`.
  - `busy` = !(state==IDLE).
- **Abort**
  - `abort` sampled high in PULSE or GAP goes to IDLE next cycle; no trigger is emitted.
  - No further increment is emitted after the abort cycle; the pulse in the abort cycle itself still occurs.
  - `abort` in IDLE or TRIG has no effect.
  - `abort` together with `start` in IDLE: start is accepted.
- **Request handling**
  - `start` while not ready is ignored and not queued.
  - `count` and `gap` changes after acceptance have no effect.
- **Arithmetic**
  - `remaining` is WIDTH bits, unsigned decrement, never wraps; N=2^WIDTH-1 is legal.
  - The gap counter is GAP_W bits; G=2^GAP_W-1 is legal.
- **Reset**
  - State=IDLE; `increment`=`trigger`=`busy`=0.
  - `remaining`=0, gap counter=0.
  - `ready` reads 0 during reset cycles and 1 from the first cycle after.
  - Reset mid-burst abandons it with no trigger.

## Timing
- Start accepted at edge T.
- k-th increment (k=1..N) is high in cycle T+1+(k-1)(G+1).
- Trigger is high in cycle T+1+N(G+1).
- `ready` returns one cycle after trigger.
- Back-to-back bursts: the next `start` may be accepted in the cycle `ready` returns; the minimum idle gap between bursts is 1 cycle.
- Latency from acceptance to first output pulse: 1 cycle.

## Structure
- Shared package `pulse_gen_pkg`:
  - state typedef (IDLE/PULSE/GAP/TRIG, 2-bit);
  - default `WIDTH`/`GAP_W` constants.
- Single module; no sub-module.
- `remaining` and the gap counter live inline with the FSM.

## Test plan
- N=3, G=0 after reset → increments in cycles T+1..T+3, trigger at T+4, `ready` at T+5; attached counter outputs 3.
- N=2, G=2 → increments at T+1 and T+4, trigger at T+7; no increment/trigger overlap in any cycle.
- N=0, G=5 → no increment, trigger at T+1, counter outputs 0; `start` pulsed during TRIG is ignored.
- N=10, G=1, `abort` asserted on the 4th increment cycle → exactly 4 increments, no trigger, `ready` the next cycle.
- N=5, G=0, `rst` asserted after the 2nd increment → all outputs 0 next cycle, `ready`=1 after `rst` drops, no trigger emitted.
- N=2^WIDTH-1, G=0, run for 100 cycles then abort → 100 consecutive increments, no wrap, no premature trigger.
